systolic_result_drain: RTL

Downstream drain stage for the buffered systolic array. It snapshots the full `ARR_HEIGHT x ARR_WIDTH` result matrix when the array's calculation-done flag rises. It then streams that matrix out one row per handshake over a valid/ready interface, so the array can start the next tile while the result is consumed.

---
 rtl/systolic_result_drain.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/systolic_result_drain.sv
// systolic_result_drain
// Captures the systolic array's result matrix on a rising calc_done_flag and
// streams it out one row per valid/ready handshake, so the array can start
// the next tile while this one is consumed.
// Optional feature: define DRAIN_RELU_EN to zero every output element whose
// sign bit is set. The snapshot itself is never modified.
module systolic_result_drain #(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     calc_done_flag,
  input  logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0]    in_c,
  output logic [ARR_WIDTH*WIDTH-1:0]               out_row,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [((ARR_HEIGHT > 1) ? $clog2(ARR_HEIGHT) : 1)-1:0] out_row_idx,
  output logic                                     out_last,
  output logic                                     busy,
  output logic                                     overflow
);

  localparam int IDX_W = (ARR_HEIGHT > 1) ? $clog2(ARR_HEIGHT) : 1;
  localparam int ROW_W = ARR_WIDTH * WIDTH;
  localparam int MAT_W = ARR_HEIGHT * ROW_W;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ARR_HEIGHT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   row_cnt_q, row_cnt_d;
  logic [MAT_W-1:0]   snap_q, snap_d;
  logic               done_d_q, done_d_d;
  logic               overflow_q, overflow_d;
  logic               start;
  logic               hs;
  logic [ROW_W-1:0]   row_sel;

  // Optional rectification of one output row; the snapshot stays untouched.
  function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] row);
    logic [ROW_W-1:0] res;
    res = row;
`ifdef DRAIN_RELU_EN
    for (int c = 0; c < ARR_WIDTH; c++) begin
      if (row[c*WIDTH + WIDTH - 1]) begin
        res[c*WIDTH +: WIDTH] = '0;
      end
    end
`endif
    return res;
  endfunction

  // The flag history resets to 1 so a level already high at reset release
  // is not mistaken for a fresh result.
  assign start = calc_done_flag & ~done_d_q;

  // Outputs come only from registered state, so out_ready never reaches out_valid.
  assign out_valid   = (state_q == DRAIN);
  assign busy        = (state_q == DRAIN);
  assign hs          = out_valid & out_ready;
  assign out_row     = out_valid ? relu_row(row_sel) : '0;
  assign out_row_idx = out_valid ? row_cnt_q : '0;
  assign out_last    = out_valid && (row_cnt_q == LAST_ROW);
  assign overflow    = overflow_q;

  // Select the snapshot row addressed by the row counter.
  always_comb begin
    row_sel = '0;
    for (int r = 0; r < ARR_HEIGHT; r++) begin
      if (row_cnt_q == IDX_W'(r)) begin
        row_sel = snap_q[r*ROW_W +: ROW_W];
      end
    end
  end

  // Next-state logic: capture, row advance, back-to-back reload, overflow.
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    snap_d     = snap_q;
    done_d_d   = calc_done_flag;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d    = in_c;
          row_cnt_d = '0;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && (row_cnt_q == LAST_ROW)) begin
          // Final row accepted: a start on this same cycle is not a collision.
          row_cnt_d = '0;
          if (start) begin
            snap_d  = in_c;
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (hs) begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
          // A result arriving mid-drain is dropped; the drain carries on.
          if (start) begin
            overflow_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        row_cnt_d = '0;
      end
    endcase
  end

  // State registers; reset discards any partially drained matrix.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      row_cnt_q  <= '0;
      snap_q     <= '0;
      done_d_q   <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      snap_q     <= snap_d;
      done_d_q   <= done_d_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
